signed_restoring_divider: RTL

//  Sequential signed integer divider, the inverse of the team's sequential signed multiplier: one quotient bit per clock.
//  It takes a signed dividend and divisor on a start pulse and produces a signed quotient and remainder.

---
 rtl/signed_restoring_divider.sv | 139 +++++++++++++
 1 files changed

// File: rtl/signed_restoring_divider.sv
// Sequential signed divider: restoring long division on operand magnitudes,
// one quotient bit per clock, results truncated toward zero.
module signed_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO       = {WIDTH{1'b0}};
  localparam logic [CW-1:0]    COUNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]    COUNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ITER   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH:0]   rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] divisor_mag_reg;
  logic [WIDTH-1:0] dividend_reg;
  logic [CW-1:0]    count_reg;
  logic             dividend_neg_reg;
  logic             divisor_neg_reg;
  logic             dbz_reg;
  logic             ovf_reg;

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] quo_signed;
  logic [WIDTH-1:0] rem_signed;
  logic             unused_rem_msb;

  // Negating the most-negative value wraps to itself, which read as unsigned
  // is exactly 2^(WIDTH-1), so no extra magnitude bit is needed.
  always_comb begin
    dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
    divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
  end

  always_comb begin
    trial      = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};
    fits       = (trial >= {1'b0, divisor_mag_reg});
    diff       = trial - {1'b0, divisor_mag_reg};
    quo_signed = (dividend_neg_reg ^ divisor_neg_reg) ? -quo_reg : quo_reg;
    rem_signed = dividend_neg_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
  end

  // The partial remainder never reaches 2^WIDTH, so its top bit is never read.
  assign unused_rem_msb = rem_reg[WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      rem_reg          <= '0;
      quo_reg          <= '0;
      divisor_mag_reg  <= '0;
      dividend_reg     <= '0;
      count_reg        <= '0;
      dividend_neg_reg <= 1'b0;
      divisor_neg_reg  <= 1'b0;
      dbz_reg          <= 1'b0;
      ovf_reg          <= 1'b0;
      quotient         <= '0;
      remainder        <= '0;
      ready            <= 1'b0;
      div_by_zero      <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dividend_reg     <= dividend;
            dividend_neg_reg <= dividend[WIDTH-1];
            divisor_neg_reg  <= divisor[WIDTH-1];
            divisor_mag_reg  <= divisor_mag;
            rem_reg          <= '0;
            quo_reg          <= dividend_mag;
            count_reg        <= COUNT_INIT;
            dbz_reg          <= (divisor == ZERO);
            ovf_reg          <= (dividend == MOST_NEG) && (divisor == ALL_ONES);
            ready            <= 1'b0;
            div_by_zero      <= 1'b0;
            overflow         <= 1'b0;
            state            <= (divisor == ZERO) ? FINISH : ITER;
          end
        end

        ITER: begin
          rem_reg   <= fits ? diff : trial;
          quo_reg   <= {quo_reg[WIDTH-2:0], fits};
          count_reg <= count_reg - COUNT_ONE;
          if (count_reg == COUNT_ONE) begin
            state <= FINISH;
          end
        end

        FINISH: begin
          if (dbz_reg) begin
            quotient    <= ALL_ONES;
            remainder   <= dividend_reg;
            div_by_zero <= 1'b1;
          end else if (ovf_reg) begin
            quotient  <= MOST_NEG;
            remainder <= ZERO;
            overflow  <= 1'b1;
          end else begin
            quotient  <= quo_signed;
            remainder <= rem_signed;
          end
          ready <= 1'b1;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
